// File: rtl/ram_arb_pkg.sv
// Shared constants for the single-port RAM arbiter: state encoding, default widths, requester ids.
package ram_arb_pkg;

  localparam int RAM_AW = 8;
  localparam int RAM_DW = 8;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_RESP = 2'd3
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin grant: combinational grant, pointer advances past each accepted grant.
module rr_arb2
  import ram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic       gnt_valid,
  output logic       gnt_id
);

  logic ptr;

  // NOTE: combinational outputs get a default before any branch so no path leaves them unassigned (no latch).
  always_comb begin
    gnt_valid = |req;
    gnt_id    = REQ0;
    if (req == 2'b11) begin
      gnt_id = ptr;
    end else if (req[1]) begin
      gnt_id = REQ1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= REQ0;
    end else if (en && gnt_valid) begin
      ptr <= ~gnt_id;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter/sequencer for the shared single-port RAM (IDLE -> RD/WR -> RESP).
// Build option: define RAM_ARB_STATS_EN to add saturating rd_count/wr_count and stat_clr.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int AW = RAM_AW,
  parameter int DW = RAM_DW
`ifdef RAM_ARB_STATS_EN
  ,
  parameter int STAT_W = 16
`endif
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          ack0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          ack1,
  output logic [DW-1:0] rdata1,
  output logic [AW-1:0] ram_addr,
  inout  wire  [DW-1:0] ram_data,
  output logic          ram_oe,
  output logic          ram_we,
  output logic          busy
`ifdef RAM_ARB_STATS_EN
  ,
  input  logic              stat_clr,
  output logic [STAT_W-1:0] rd_count,
  output logic [STAT_W-1:0] wr_count
`endif
);

  state_t        state, state_nx;
  logic          gnt_valid, gnt_id, grant, sel_we, drive_en;
  logic          lat_id;
  logic [AW-1:0] lat_addr;
  logic [DW-1:0] lat_wdata;

  rr_arb2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       ({req1, req0}),
    .en        (state == ST_IDLE),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  assign grant  = (state == ST_IDLE) && gnt_valid;
  assign sel_we = (gnt_id == REQ1) ? we1 : we0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    ram_oe   = 1'b0;
    ram_we   = 1'b0;
    drive_en = 1'b0;
    ack0     = 1'b0;
    ack1     = 1'b0;
    busy     = (state != ST_IDLE);
    case (state)
      ST_IDLE: if (gnt_valid) state_nx = sel_we ? ST_WR : ST_RD;
      ST_RD: begin
        ram_oe   = 1'b1;
        state_nx = ST_RESP;
      end
      ST_WR: begin
        ram_we   = 1'b1;
        drive_en = 1'b1;
        state_nx = ST_RESP;
      end
      ST_RESP: begin
        ack0     = (lat_id == REQ0);
        ack1     = (lat_id == REQ1);
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // RAM pins come only from these registers, never straight from a requester.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_id    <= REQ0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else if (grant) begin
      lat_id    <= gnt_id;
      lat_addr  <= (gnt_id == REQ1) ? addr1 : addr0;
      lat_wdata <= (gnt_id == REQ1) ? wdata1 : wdata0;
    end
  end

  assign ram_addr = lat_addr;
  assign ram_data = drive_en ? lat_wdata : {DW{1'bz}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata0 <= '0;
      rdata1 <= '0;
    end else if (state == ST_RD) begin
      if (lat_id == REQ1) rdata1 <= ram_data;
      else                rdata0 <= ram_data;
    end
  end

`ifdef RAM_ARB_STATS_EN
  localparam logic [STAT_W-1:0] STAT_MAX = '1;

  // Counting on RD/WR exit is the same edge as RESP entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_count <= '0;
      wr_count <= '0;
    end else if (stat_clr) begin
      rd_count <= '0;
      wr_count <= '0;
    end else begin
      if (state == ST_RD && rd_count != STAT_MAX) rd_count <= rd_count + STAT_W'(1);
      if (state == ST_WR && wr_count != STAT_MAX) wr_count <= wr_count + STAT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: stimulus pushes expected accesses, a negedge monitor checks bus and acks.
module tb_ram_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [7:0] addr0 = '0, wdata0 = '0, addr1 = '0, wdata1 = '0;
  wire        ack0, ack1, ram_oe, ram_we, busy;
  wire  [7:0] rdata0, rdata1, ram_addr;
  wire  [7:0] ram_data;
`ifdef RAM_ARB_STATS_EN
  logic        stat_clr = 1'b0;
  wire  [15:0] rd_count, wr_count;
`endif

  logic [7:0] mem [256];

  typedef struct {
    logic       id;
    logic       we;
    logic [7:0] addr;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] rd_model [2];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         bus_cyc = 0;

  always #5 clk = ~clk;

  ram_arbiter dut (
    .clk      (clk),
    .rst      (rst),
    .req0     (req0),
    .we0      (we0),
    .addr0    (addr0),
    .wdata0   (wdata0),
    .ack0     (ack0),
    .rdata0   (rdata0),
    .req1     (req1),
    .we1      (we1),
    .addr1    (addr1),
    .wdata1   (wdata1),
    .ack1     (ack1),
    .rdata1   (rdata1),
    .ram_addr (ram_addr),
    .ram_data (ram_data),
    .ram_oe   (ram_oe),
    .ram_we   (ram_we),
    .busy     (busy)
`ifdef RAM_ARB_STATS_EN
    ,
    .stat_clr (stat_clr),
    .rd_count (rd_count),
    .wr_count (wr_count)
`endif
  );

  // Behavioural single-port RAM: edge write, combinational read onto the shared bus.
  assign ram_data = ram_oe ? mem[ram_addr] : 8'hzz;
  always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_acc(input logic id, input logic w, input logic [7:0] a, input logic [7:0] d);
    exp_t e;
    e.id = id; e.we = w; e.addr = a; e.data = d;
    exp_q.push_back(e);
  endtask

  // Holds req for nacks consecutive acks, then drops it on the edge ending the last ack.
  task automatic access(input logic id, input logic w, input logic [7:0] a, input logic [7:0] d,
                        input int nacks, input int exp_lat);
    int  n;
    bit  got;
    @(negedge clk);
    if (id) begin we1 = w; addr1 = a; wdata1 = d; req1 = 1'b1; end
    else    begin we0 = w; addr0 = a; wdata0 = d; req0 = 1'b1; end
    for (int k = 0; k < nacks; k++) begin
      n = 0;
      got = 1'b0;
      while (!got && n < 20) begin
        @(negedge clk);
        n++;
        got = id ? ack1 : ack0;
      end
      check("ack_timeout", 32'(got), 32'd1);
      if (got && exp_lat > 0) check("ack_latency_from_req", n, exp_lat);
    end
    @(posedge clk);
    #1;
    if (id) req1 = 1'b0;
    else    req0 = 1'b0;
  endtask

  task automatic pulse_rst;
    @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    #1 rst = 1'b0;
  endtask

  // Monitor: every cycle, compare the RAM bus and any ack against the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        rd_model[0] = 8'h00;
        rd_model[1] = 8'h00;
      end else begin
        check("oe_we_exclusive", 32'(ram_oe & ram_we), 32'd0);
        if (ram_oe | ram_we) begin
          if (exp_q.size() == 0) begin
            check("bus_unexpected", 32'd1, 32'd0);
          end else begin
            check("bus_we", 32'(ram_we), 32'(exp_q[0].we));
            check("bus_addr", 32'(ram_addr), 32'(exp_q[0].addr));
            check("bus_data", 32'(ram_data), 32'(exp_q[0].data));
            check("busy", 32'(busy), 32'd1);
          end
          bus_cyc = cyc;
        end else begin
          check("bus_released", 32'(ram_data === 8'hzz), 32'd1);
        end
        if (ack0 | ack1) begin
          if (exp_q.size() == 0) begin
            check("ack_unexpected", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("ack_pair", 32'({ack1, ack0}), e.id ? 32'd2 : 32'd1);
            check("ack_after_bus", cyc - bus_cyc, 32'd1);
            if (!e.we) rd_model[e.id] = e.data;
            check("rdata0", 32'(rdata0), 32'(rd_model[0]));
            check("rdata1", 32'(rdata1), 32'(rd_model[1]));
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int  n;
    bit  seen;

    // Reset state
    #1;
    check("rst_ack0", 32'(ack0), 32'd0);
    check("rst_ack1", 32'(ack1), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_oe", 32'(ram_oe), 32'd0);
    check("rst_we", 32'(ram_we), 32'd0);
    check("rst_addr", 32'(ram_addr), 32'd0);
    check("rst_rdata0", 32'(rdata0), 32'd0);
    check("rst_rdata1", 32'(rdata1), 32'd0);
    check("rst_bus_z", 32'(ram_data === 8'hzz), 32'd1);
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b0;

    // 1: single write, ack two cycles after the sampling edge
    expect_acc(1'b0, 1'b1, 8'h10, 8'hA5);
    access(1'b0, 1'b1, 8'h10, 8'hA5, 1, 2);

    // 2: read it back; rdata1 must stay 0
    expect_acc(1'b0, 1'b0, 8'h10, 8'hA5);
    access(1'b0, 1'b0, 8'h10, 8'hA5, 1, 2);

    // 3: contention from a fresh pointer, each side held for two acks -> 0,1,0,1
    pulse_rst();
    expect_acc(1'b0, 1'b1, 8'h00, 8'h11);
    expect_acc(1'b1, 1'b1, 8'h00, 8'h22);
    expect_acc(1'b0, 1'b1, 8'h00, 8'h11);
    expect_acc(1'b1, 1'b1, 8'h00, 8'h22);
    fork
      access(1'b0, 1'b1, 8'h00, 8'h11, 2, 0);
      access(1'b1, 1'b1, 8'h00, 8'h22, 2, 0);
    join
    check("mem0_last_writer", 32'(mem[0]), 32'h22);
    expect_acc(1'b1, 1'b0, 8'h00, 8'h22);
    access(1'b1, 1'b0, 8'h00, 8'h22, 1, 2);

    // 4: top address, no wrap
    expect_acc(1'b1, 1'b1, 8'hFF, 8'h5A);
    access(1'b1, 1'b1, 8'hFF, 8'h5A, 1, 2);
    expect_acc(1'b1, 1'b0, 8'hFF, 8'h5A);
    access(1'b1, 1'b0, 8'hFF, 8'h5A, 1, 2);
    check("mem00_untouched", 32'(mem[0]), 32'h22);

    // 5: reset during WR aborts without an ack
    expect_acc(1'b0, 1'b1, 8'h20, 8'h77);
    @(negedge clk);
    we0 = 1'b1; addr0 = 8'h20; wdata0 = 8'h77; req0 = 1'b1;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 10) begin
      @(negedge clk);
      n++;
      seen = ram_we;
    end
    check("wr_phase_seen", 32'(seen), 32'd1);
    #2;
    rst  = 1'b1;
    req0 = 1'b0;
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_we", 32'(ram_we), 32'd0);
    check("abort_bus_z", 32'(ram_data === 8'hzz), 32'd1);
    check("abort_ack", 32'({ack1, ack0}), 32'd0);
    @(negedge clk);
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    expect_acc(1'b0, 1'b0, 8'hFF, 8'h5A);
    access(1'b0, 1'b0, 8'hFF, 8'h5A, 1, 2);

`ifdef RAM_ARB_STATS_EN
    // 6: counters, clear, saturation
    @(negedge clk);
    stat_clr = 1'b1;
    @(negedge clk);
    stat_clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      expect_acc(1'b0, 1'b1, 8'h40 + 8'(i), 8'hC0 + 8'(i));
      access(1'b0, 1'b1, 8'h40 + 8'(i), 8'hC0 + 8'(i), 1, 2);
    end
    for (int i = 0; i < 2; i++) begin
      expect_acc(1'b1, 1'b0, 8'h40 + 8'(i), 8'hC0 + 8'(i));
      access(1'b1, 1'b0, 8'h40 + 8'(i), 8'hC0 + 8'(i), 1, 2);
    end
    check("wr_count_3", 32'(wr_count), 32'd3);
    check("rd_count_2", 32'(rd_count), 32'd2);
    @(negedge clk);
    stat_clr = 1'b1;
    @(negedge clk);
    stat_clr = 1'b0;
    check("wr_count_clr", 32'(wr_count), 32'd0);
    check("rd_count_clr", 32'(rd_count), 32'd0);
    force dut.wr_count = 16'hFFFF;
    @(posedge clk);
    #1 release dut.wr_count;
    expect_acc(1'b0, 1'b1, 8'h50, 8'h99);
    access(1'b0, 1'b1, 8'h50, 8'h99, 1, 2);
    check("wr_count_sat", 32'(wr_count), 32'hFFFF);
`endif

    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer for the team's single-port 8-bit RAM.
- The RAM has a shared tristate data bus, a write on the clock edge, and a combinational read.
- Each requester issues one read or write through a req/ack handshake.
- The block owns the RAM addr/oe/we pins and the write side of the data bus, and guarantees oe and we are never asserted together.

Parameters:
- AW, 8, RAM address width (256 locations).
- DW, 8, RAM data width.
- STAT_W, 16, width of the access counters (optional feature only).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req0  input  1  requester 0 access request; held high until ack0.
- we0  input  1  requester 0: 1 = write, 0 = read; stable while req0 is high.
- addr0  input  AW  requester 0 address; stable while req0 is high.
- wdata0  input  DW  requester 0 write data; stable while req0 is high.
- ack0  output  1  one-cycle completion pulse to requester 0.
- rdata0  output  DW  requester 0 read data; valid when ack0 is high, held until the next requester-0 read.
- req1, we1, addr1, wdata1, ack1, rdata1: same as requester 0, for requester 1.
- ram_addr  output  AW  RAM address.
- ram_data  inout  DW  RAM data bus; driven by this block only in state WR, otherwise high-Z.
- ram_oe  output  1  RAM output enable.
- ram_we  output  1  RAM write enable.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous, immediate):
  - state = IDLE; ack0 = ack1 = 0; rdata0 = rdata1 = 0.
  - ram_oe = ram_we = 0; ram_addr = 0; ram_data high-Z.
  - Priority pointer = requester 0; busy = 0.
- States:
  - IDLE: no request pending or granting. Moves to RD or WR when a request is granted.
  - RD: read in progress. Always moves to RESP after one cycle.
  - WR: write in progress. Always moves to RESP after one cycle.
  - RESP: ack pulse. Always returns to IDLE.
- Arbitration (in IDLE):
  - If only one req is high, grant it.
  - If both are high, grant the requester named by the priority pointer.
  - On each grant, set the pointer to the other requester.
  - Latch the granted requester's id, we, addr and wdata into internal registers. The RAM pins are driven only from these registers.
- RD:
  - ram_addr = latched addr; ram_oe = 1; ram_we = 0; ram_data high-Z.
  - At the closing edge, the granted requester's rdata register samples ram_data.
- WR:
  - ram_addr = latched addr; ram_we = 1; ram_oe = 0; ram_data driven with latched wdata.
  - The RAM captures the data at the closing edge.
- RESP:
  - ram_oe = ram_we = 0; ram_data high-Z; the granted requester's ack = 1 for exactly one cycle.
- Latency:
  - Request sampled in IDLE at edge k → RD/WR during cycle k+1 → ack high during cycle k+2.
  - Throughput: one access per 3 cycles.
- Handshake:
  - The requester may drop req on the edge that ends ack.
  - A req still high in IDLE after its ack is treated as a new request.
- The other requester's req arriving mid-access is held pending and granted at the next IDLE.
- Under continuous contention, grants alternate 0,1,0,1.
- Bus turnaround is guaranteed by the state structure: ram_data is driven only in WR, and the RAM drives only during RD. No cycle has both oe and we high.
- Address wrap: addresses are used verbatim with no arithmetic; 8'hFF is legal.
- rst asserted mid-access:
  - Abort immediately; no ack is issued.
  - An in-flight write may or may not have landed in the RAM.
  - Requesters must re-issue after reset.

Optional Feature:
- Macro: RAM_ARB_STATS_EN.
- Defined:
  - Adds outputs rd_count and wr_count, each STAT_W wide, reset to 0.
  - Each increments by 1 on entry to RESP for a completed read or write respectively.
  - Each saturates at all-ones and does not wrap.
  - Adds input stat_clr; a high level zeroes both counters synchronously, with priority over increment.
- Not defined: those ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package ram_arb_pkg:
  - State encoding constants ST_IDLE, ST_RD, ST_WR, ST_RESP.
  - Default widths AW = 8, DW = 8.
  - Requester id constants REQ0, REQ1.
- One sub-module, rr_arb2: two-input round-robin grant logic with the priority-pointer register; combinational grant, registered pointer update.
- FSM, latches and the tristate driver stay in ram_arbiter.

Test Plan:
1. Reset, then requester 0 writes 8'hA5 to address 8'h10 → ram_we high for exactly 1 cycle with ram_data = A5, ram_addr = 10; ack0 pulses at cycle k+2; ram_oe stays 0 throughout.
2. Requester 0 then reads address 8'h10 → ram_oe high for 1 cycle with ram_data not driven by the arbiter; rdata0 = A5 when ack0 pulses; rdata1 unchanged.
3. Both requesters assert together: req0 write 8'h11 to 8'h00, req1 write 8'h22 to 8'h00, both held, and each re-asserts once more → grant order 0,1,0,1; each access completes in 3 cycles; final memory[0] = 22.
4. Requester 1 writes 8'h5A at address 8'hFF, then reads it back → rdata1 = 5A; no wrap to 0; bench checks ram_oe & ram_we == 0 every cycle.
5. rst pulsed during WR → ack0/ack1 stay 0; state = IDLE and ram_data high-Z in the same cycle; a subsequent request completes normally.
6. With RAM_ARB_STATS_EN defined: 3 writes and 2 reads → wr_count = 3, rd_count = 2; stat_clr pulse → both 0; forced preload to 16'hFFFF plus one more write → wr_count stays FFFF.
